// File: rtl/alu_op_dispatcher.sv
// Initiator side of the ALU16 start/finish protocol: takes one request at a time,
// drives start/operands to the control unit, captures the result and returns a response.
module alu_op_dispatcher #(
    parameter int TIMEOUT   = 64,
    parameter int LEGAL_OPS = 8
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [15:0] req_a,
    input  logic [15:0] req_b,
    output logic [3:0]  alu_s,
    output logic        alu_start,
    output logic [15:0] alu_x,
    output logic [15:0] alu_y,
    input  logic        alu_finish,
    input  logic [15:0] alu_hi,
    input  logic [15:0] alu_lo,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [3:0]  rsp_op,
    output logic [15:0] rsp_hi,
    output logic [15:0] rsp_lo,
    output logic        rsp_illegal,
    output logic        rsp_timeout,
    output logic        busy,
    output logic        err_spurious
);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP, S_DRAIN} state_t;

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    state_t        state, state_nx;
    logic [TW-1:0] timer;
    logic          timer_last;
    logic          op_legal;

    assign timer_last = (timer == T_LAST);
    assign op_legal   = (32'(req_op) < LEGAL_OPS);

    // Handshake outputs are pure state decodes, so no input reaches an output combinationally
    assign req_ready = (state == S_IDLE);
    assign alu_start = (state == S_ISSUE);
    assign rsp_valid = (state == S_RESP);
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (req_valid) state_nx = op_legal ? S_ISSUE : S_RESP;
            S_ISSUE: state_nx = S_WAIT;
            S_WAIT:  if (alu_finish || timer_last) state_nx = S_RESP;
            S_RESP:  if (rsp_ready) state_nx = rsp_timeout ? S_DRAIN : S_IDLE;
            S_DRAIN: if (alu_finish || timer_last) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            alu_s        <= '0;
            alu_x        <= '0;
            alu_y        <= '0;
            rsp_op       <= '0;
            rsp_hi       <= '0;
            rsp_lo       <= '0;
            rsp_illegal  <= 1'b0;
            rsp_timeout  <= 1'b0;
            timer        <= '0;
            err_spurious <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    timer <= '0;
                    if (req_valid) begin
                        rsp_op      <= req_op;
                        rsp_hi      <= '0;
                        rsp_lo      <= '0;
                        rsp_illegal <= !op_legal;
                        rsp_timeout <= 1'b0;
                        // Illegal ops never reach the ALU, so its inputs keep their old values
                        if (op_legal) begin
                            alu_s <= req_op;
                            alu_x <= req_a;
                            alu_y <= req_b;
                        end
                    end
                end
                S_ISSUE: timer <= '0;
                S_WAIT: begin
                    if (alu_finish) begin
                        rsp_hi <= alu_hi;
                        rsp_lo <= alu_lo;
                        timer  <= '0;
                    end else if (timer_last) begin
                        rsp_timeout <= 1'b1;
                        rsp_hi      <= '0;
                        rsp_lo      <= '0;
                        timer       <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_RESP: timer <= '0;
                S_DRAIN: begin
                    if (alu_finish || timer_last) timer <= '0;
                    else                          timer <= timer + 1'b1;
                end
                default: timer <= '0;
            endcase

            if (alu_finish && (state == S_IDLE || state == S_ISSUE || state == S_RESP))
                err_spurious <= 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_op_dispatcher.sv
// Directed bench for alu_op_dispatcher: table of ops against a scripted control-unit model,
// plus hand sequences for reset, timeout/drain and spurious-finish corners.
module tb_alu_op_dispatcher;

    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        req_valid, req_ready;
    logic [3:0]  req_op;
    logic [15:0] req_a, req_b;
    logic [3:0]  alu_s;
    logic        alu_start;
    logic [15:0] alu_x, alu_y;
    logic        alu_finish;
    logic [15:0] alu_hi, alu_lo;
    logic        rsp_valid, rsp_ready;
    logic [3:0]  rsp_op;
    logic [15:0] rsp_hi, rsp_lo;
    logic        rsp_illegal, rsp_timeout, busy, err_spurious;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_op_dispatcher #(.TIMEOUT(TIMEOUT), .LEGAL_OPS(8)) dut (
        .clk(clk), .rst_b(rst_b),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .alu_s(alu_s), .alu_start(alu_start), .alu_x(alu_x), .alu_y(alu_y),
        .alu_finish(alu_finish), .alu_hi(alu_hi), .alu_lo(alu_lo),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_op(rsp_op),
        .rsp_hi(rsp_hi), .rsp_lo(rsp_lo), .rsp_illegal(rsp_illegal),
        .rsp_timeout(rsp_timeout), .busy(busy), .err_spurious(err_spurious)
    );

    // delay: WAIT cycle (1-based) in which the model raises finish; 0 = never finishes
    typedef struct {
        logic [3:0]  op;
        logic [15:0] a, b;
        int          delay;
        int          hold;
        logic [15:0] fhi, flo;
        logic        ill, tmo;
        logic [15:0] ehi, elo;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Issues one request, plays the control unit, checks the response and accepts it.
    task automatic apply(input vec_t v, input string tag);
        int cnt, starts, exp_lat;
        @(negedge clk);
        chk({tag, " req_ready idle"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_op = v.op; req_a = v.a; req_b = v.b;
        alu_hi = v.fhi; alu_lo = v.flo;
        @(negedge clk);
        req_valid = 1'b0;
        if (v.ill) begin
            chk({tag, " no start"}, 32'(alu_start), 32'd0);
        end else begin
            chk({tag, " start"}, 32'(alu_start), 32'd1);
            chk({tag, " alu_s"}, 32'(alu_s), 32'(v.op));
            chk({tag, " alu_x"}, 32'(alu_x), 32'(v.a));
            chk({tag, " alu_y"}, 32'(alu_y), 32'(v.b));
            cnt = 0; starts = 0;
            while (!rsp_valid && cnt < 200) begin
                @(negedge clk);
                cnt++;
                alu_finish = 1'b0;
                if (alu_start) starts++;
                if (!rsp_valid && cnt == v.delay) alu_finish = 1'b1;
            end
            alu_finish = 1'b0;
            exp_lat = (v.delay == 0) ? TIMEOUT + 1 : v.delay + 1;
            chk({tag, " latency"}, 32'(cnt), 32'(exp_lat));
            chk({tag, " single start"}, 32'(starts), 32'd0);
            chk({tag, " alu_s held"}, 32'(alu_s), 32'(v.op));
        end
        chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, " rsp_op"}, 32'(rsp_op), 32'(v.op));
        chk({tag, " rsp_hi"}, 32'(rsp_hi), 32'(v.ehi));
        chk({tag, " rsp_lo"}, 32'(rsp_lo), 32'(v.elo));
        chk({tag, " flags"}, {30'd0, rsp_illegal, rsp_timeout}, {30'd0, v.ill, v.tmo});
        chk({tag, " req_ready busy"}, {30'd0, req_ready, busy}, 32'd1);
        for (int i = 0; i < v.hold; i++) begin
            req_valid = 1'b1; req_op = 4'd5;
            @(negedge clk);
            chk({tag, " stall valid"}, 32'(rsp_valid), 32'd1);
            chk({tag, " stall lo"}, 32'(rsp_lo), 32'(v.elo));
            chk({tag, " stall req_ready"}, 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({tag, " rsp dropped"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        int cnt, extra;
        vec_t tv;

        //          op     a        b        dly hold fhi      flo      ill   tmo   ehi      elo
        vecs[0] = '{4'd0, 16'h0003, 16'h0004, 5,  0, 16'h0000, 16'h0007, 1'b0, 1'b0, 16'h0000, 16'h0007};
        vecs[1] = '{4'd1, 16'h0010, 16'h0001, 3,  3, 16'h0000, 16'h000F, 1'b0, 1'b0, 16'h0000, 16'h000F};
        vecs[2] = '{4'd2, 16'h0003, 16'h8000, 20, 0, 16'h0001, 16'h8000, 1'b0, 1'b0, 16'h0001, 16'h8000};
        vecs[3] = '{4'd7, 16'h1111, 16'h2222, 64, 1, 16'hBEEF, 16'h1234, 1'b0, 1'b0, 16'hBEEF, 16'h1234};
        vecs[4] = '{4'd8, 16'h0001, 16'h0002, 0,  0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0000};
        vecs[5] = '{4'hF, 16'hFFFF, 16'hFFFF, 0,  2, 16'h5555, 16'h5555, 1'b1, 1'b0, 16'h0000, 16'h0000};
        vecs[6] = '{4'd3, 16'hA5A5, 16'h5A5A, 1,  0, 16'hA5A5, 16'h5A5A, 1'b0, 1'b0, 16'hA5A5, 16'h5A5A};

        rst_b = 1'b0; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0;
        alu_finish = 1'b0; alu_hi = '0; alu_lo = '0; rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset ctrl", {27'd0, req_ready, alu_start, rsp_valid, busy, err_spurious}, 32'h10);
        chk("reset alu", {alu_s, alu_x, alu_y}, 36'd0);
        chk("reset rsp", {rsp_op, rsp_hi, rsp_lo, rsp_illegal, rsp_timeout}, 38'd0);
        rst_b = 1'b1;

        for (int i = 0; i < 7; i++) begin
            apply(vecs[i], $sformatf("v%0d", i));
            chk($sformatf("v%0d back to idle", i), {30'd0, req_ready, busy}, 32'd2);
        end
        chk("no spurious after table", 32'(err_spurious), 32'd0);

        // Timeout, then a late finish swallowed in DRAIN
        tv = '{4'd4, 16'h0042, 16'h0024, 0, 1, 16'hDEAD, 16'hBEEF, 1'b0, 1'b1, 16'h0000, 16'h0000};
        apply(tv, "tmo1");
        chk("tmo1 drain busy", {30'd0, req_ready, busy}, 32'd1);
        repeat (4) @(negedge clk);
        alu_finish = 1'b1;
        @(negedge clk);
        alu_finish = 1'b0;
        chk("tmo1 drain exit", {30'd0, req_ready, busy}, 32'd2);
        extra = 0;
        repeat (5) begin
            @(negedge clk);
            if (rsp_valid) extra++;
        end
        chk("tmo1 no extra rsp", 32'(extra), 32'd0);
        chk("tmo1 no spurious", 32'(err_spurious), 32'd0);

        // Timeout, DRAIN expires on its own after TIMEOUT cycles
        tv.op = 4'd6;
        apply(tv, "tmo2");
        cnt = 1;
        while (busy && cnt < 200) begin
            @(negedge clk);
            if (busy) cnt++;
        end
        chk("tmo2 drain length", 32'(cnt), 32'(TIMEOUT));
        chk("tmo2 no spurious", 32'(err_spurious), 32'd0);

        // Stray finish in IDLE is sticky across later ops
        @(negedge clk);
        alu_finish = 1'b1;
        @(negedge clk);
        alu_finish = 1'b0;
        chk("spurious set", 32'(err_spurious), 32'd1);
        chk("spurious no rsp", 32'(rsp_valid), 32'd0);
        apply(vecs[0], "post_spur");
        chk("spurious sticky", 32'(err_spurious), 32'd1);

        // Reset in the middle of WAIT
        @(negedge clk);
        req_valid = 1'b1; req_op = 4'd1; req_a = 16'h0009; req_b = 16'h0001;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rst_mid start", 32'(alu_start), 32'd1);
        repeat (3) @(negedge clk);
        chk("rst_mid in wait", {30'd0, req_ready, busy}, 32'd1);
        rst_b = 1'b0;
        #1;
        chk("rst_mid ctrl", {27'd0, req_ready, alu_start, rsp_valid, busy, err_spurious}, 32'h10);
        chk("rst_mid alu_s", 32'(alu_s), 32'd0);
        @(negedge clk);
        rst_b = 1'b1;
        extra = 0;
        repeat (TIMEOUT + 4) begin
            @(negedge clk);
            if (rsp_valid || busy) extra++;
        end
        chk("rst_mid op lost", 32'(extra), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
